notch_coeff_loader: RTL and testbench

- Configuration writer for the cascaded IIR notch stages in the DFE chain.
- Accepts a valid/ready word stream of coefficient frames and assembles each frame into a per-stage shadow bank.
- Commits all pending shadow banks to the live coefficient bus in a single cycle. The commit happens only while the filters are not taking a sample, so a biquad never computes with a mix of old and new coefficients.

---
 rtl/dfe_cfg_pkg.sv | 22 ++
 rtl/notch_coeff_bank.sv | 44 ++++
 rtl/notch_coeff_loader.sv | 127 ++++++++++++
 tb/tb_notch_coeff_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfe_cfg_pkg.sv
// Shared constants and types for DFE configuration loaders.
// Coefficient slot order within a stage is b0,b1,b2,a1,a2 from the LSB.
package dfe_cfg_pkg;

  localparam logic [3:0] DFE_SYNC        = 4'hA;
  localparam int         DFE_UNITY       = 16384;
  localparam int         COEFS_PER_STAGE = 5;

  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } load_state_t;

endpackage

// File: rtl/notch_coeff_bank.sv
// One notch stage: shadow coefficient set, live coefficient set and dirty flag.
// Shadow is written by a complete frame; live follows shadow only on commit.
module notch_coeff_bank
  import dfe_cfg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int UNITY = DFE_UNITY
) (
  input  logic                               CLK,
  input  logic                               rst,
  input  logic                               i_wr,
  input  logic [COEFS_PER_STAGE*WIDTH-1:0]   i_wr_data,
  input  logic                               i_commit,
  output logic [COEFS_PER_STAGE*WIDTH-1:0]   o_live,
  output logic                               o_dirty
);

  localparam int BW = COEFS_PER_STAGE * WIDTH;
  localparam logic [BW-1:0] PASSTHRU = BW'(WIDTH'(UNITY)) << (B0 * WIDTH);

  logic [BW-1:0] r_shadow;
  logic [BW-1:0] r_live;
  logic          r_dirty;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_shadow <= PASSTHRU;
      r_live   <= PASSTHRU;
      r_dirty  <= 1'b0;
    end else begin
      if (i_wr) begin
        r_shadow <= i_wr_data;
        r_dirty  <= 1'b1;
      end else if (i_commit && r_dirty) begin
        r_live  <= r_shadow;
        r_dirty <= 1'b0;
      end
    end
  end

  assign o_live  = r_live;
  assign o_dirty = r_dirty;

endmodule

// File: rtl/notch_coeff_loader.sv
// Frame parser and commit control for the cascaded notch coefficient banks.
// Commit is held off while sample_en is high so a biquad never sees a mixed set.
module notch_coeff_loader
  import dfe_cfg_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter int         NUM_STAGES = 2,
  parameter logic [3:0] SYNC       = DFE_SYNC,
  parameter int         UNITY      = DFE_UNITY
) (
  input  logic                                    CLK,
  input  logic                                    rst,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [WIDTH-1:0]                        cfg_data,
  input  logic                                    sample_en,
  output logic [NUM_STAGES*COEFS_PER_STAGE*WIDTH-1:0] coeff_bus,
  output logic                                    pending,
  output logic                                    commit_done,
  output logic                                    cfg_err
);

  localparam int SW = COEFS_PER_STAGE * WIDTH;

  load_state_t r_state;
  load_state_t w_next;
  logic [2:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [COEFS_PER_STAGE-1:0][WIDTH-1:0] r_frame;
  logic        r_cfg_err;
  logic        r_commit_done;

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_sync_ok;
  logic                  w_idx_ok;
  logic                  w_last;
  logic                  w_commit;
  logic [NUM_STAGES-1:0] w_dirty;

  assign w_acc     = cfg_valid && cfg_ready;
  assign w_sync_ok = (cfg_data[WIDTH-1 -: 4] == SYNC);
  assign w_idx_ok  = ({28'd0, cfg_data[3:0]} < 32'(NUM_STAGES));
  assign w_last    = (r_cnt == 3'(A2));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_acc && w_sync_ok) w_next = w_idx_ok ? LOAD : DRAIN;
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_acc && w_last) w_next = WRITE;
      end
      DRAIN: begin
        w_ready = 1'b1;
        if (w_acc && w_last) w_next = IDLE;
      end
      WRITE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign cfg_ready = w_ready && !rst;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt   <= 3'd0;
      r_idx   <= 4'd0;
      r_frame <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_cnt <= 3'd0;
          r_idx <= cfg_data[3:0];
        end
        LOAD: if (w_acc) begin
          r_frame[r_cnt] <= cfg_data;
          r_cnt          <= w_last ? 3'd0 : r_cnt + 3'd1;
        end
        DRAIN: if (w_acc) r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // A WRITE edge never commits; the next eligible edge picks up the new stage too.
  assign w_commit = (|w_dirty) && !sample_en && (r_state != WRITE);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cfg_err     <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_cfg_err     <= (r_state == IDLE) && w_acc && !(w_sync_ok && w_idx_ok);
      r_commit_done <= w_commit;
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    notch_coeff_bank #(
      .WIDTH (WIDTH),
      .UNITY (UNITY)
    ) u_bank (
      .CLK       (CLK),
      .rst       (rst),
      .i_wr      ((r_state == WRITE) && (r_idx == 4'(s))),
      .i_wr_data (r_frame),
      .i_commit  (w_commit),
      .o_live    (coeff_bus[s*SW +: SW]),
      .o_dirty   (w_dirty[s])
    );
  end

  assign pending     = |w_dirty;
  assign commit_done = r_commit_done;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_notch_coeff_loader.sv
// Self-checking bench for notch_coeff_loader against a frame-level reference model.
module tb_notch_coeff_loader;

  localparam int W  = 16;
  localparam int NS = 2;
  localparam int BW = NS * 5 * W;

  logic          CLK = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_data;
  logic          sample_en;
  logic [BW-1:0] coeff_bus;
  logic          pending;
  logic          commit_done;
  logic          cfg_err;

  notch_coeff_loader #(.WIDTH(W), .NUM_STAGES(NS)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .sample_en   (sample_en),
    .coeff_bus   (coeff_bus),
    .pending     (pending),
    .commit_done (commit_done),
    .cfg_err     (cfg_err)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int n_commits = 0;

  logic [W-1:0] m_live   [NS][5];
  logic [W-1:0] m_shadow [NS][5];
  bit           m_dirty  [NS];
  logic [W-1:0] cw [5];

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_bus();
    logic [BW-1:0] b;
    b = '0;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 5; k++) b[(s*5+k)*W +: W] = m_live[s][k];
    return b;
  endfunction

  function automatic logic exp_pending();
    logic p;
    p = 1'b0;
    for (int s = 0; s < NS; s++) p |= m_dirty[s];
    return p;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 5; k++) begin
        m_live[s][k]   = (k == 0) ? 16'd16384 : 16'd0;
        m_shadow[s][k] = (k == 0) ? 16'd16384 : 16'd0;
      end
      m_dirty[s] = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [W-1:0] hdr);
    int idx;
    idx = int'(hdr[3:0]);
    if (hdr[15:12] == 4'hA && idx < NS) begin
      for (int k = 0; k < 5; k++) m_shadow[idx][k] = cw[k];
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int s = 0; s < NS; s++)
      if (m_dirty[s]) begin
        for (int k = 0; k < 5; k++) m_live[s][k] = m_shadow[s][k];
        m_dirty[s] = 1'b0;
      end
  endtask

  task automatic rand_coefs();
    for (int k = 0; k < 5; k++) cw[k] = 16'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [W-1:0] d, input int gap);
    int n;
    cfg_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    cfg_data  = d;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("accept_timeout", {159'd0, cfg_ready}, 1);
    @(posedge CLK);
    @(negedge CLK);
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] hdr, input int gapmax);
    send_word(hdr, $urandom_range(0, gapmax));
    for (int k = 0; k < 5; k++) send_word(cw[k], $urandom_range(0, gapmax));
  endtask

  logic          se_q = 1'b0;
  logic [BW-1:0] bus_q;

  always @(posedge CLK) begin
    se_q  <= sample_en;
    bus_q <= coeff_bus;
    if (commit_done) n_commits <= n_commits + 1;
  end

  always @(negedge CLK)
    if (se_q && !rst) check("bus_hold", coeff_bus, bus_q);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [3:0] sy;
    logic [3:0] ix;
    logic [W-1:0] hdr;
    bit se;

    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; sample_en = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("ready_in_rst", {159'd0, cfg_ready}, 0);
    rst = 1'b0;
    @(negedge CLK);
    check("reset_bus", coeff_bus, exp_bus());
    check("reset_pending", {159'd0, pending}, 0);
    check("reset_ready", {159'd0, cfg_ready}, 1);
    check("reset_err", {159'd0, cfg_err}, 0);

    // Directed frame to stage 1 with exact commit latency
    cw[0] = 16'd16384; cw[1] = 16'(-26214); cw[2] = 16'd16384;
    cw[3] = 16'(-24904); cw[4] = 16'd15729;
    send_frame(16'hA001, 0);
    model_frame(16'hA001);
    check("lat_e1_pending", {159'd0, pending}, 0);
    check("lat_e1_bus", coeff_bus, exp_bus());
    @(negedge CLK);
    check("lat_e2_pending", {159'd0, pending}, 1);
    check("lat_e2_done", {159'd0, commit_done}, 0);
    check("lat_e2_bus", coeff_bus, exp_bus());
    @(negedge CLK);
    model_commit();
    check("lat_e3_done", {159'd0, commit_done}, 1);
    check("lat_e3_bus", coeff_bus, exp_bus());
    check("lat_e3_pending", {159'd0, pending}, 0);
    check("stage0_untouched", {80'd0, coeff_bus[79:0]}, {80'd0, 64'd0, 16'd16384});
    @(negedge CLK);
    check("done_one_cycle", {159'd0, commit_done}, 0);

    // Commit deferred while sample_en is high
    sample_en = 1'b1;
    rand_coefs();
    send_frame(16'hA001, 0);
    model_frame(16'hA001);
    repeat (20) @(negedge CLK);
    check("defer_pending", {159'd0, pending}, 1);
    check("defer_bus", coeff_bus, exp_bus());
    sample_en = 1'b0;
    @(negedge CLK);
    model_commit();
    check("defer_done", {159'd0, commit_done}, 1);
    check("defer_bus_new", coeff_bus, exp_bus());

    // Bad sync header
    send_word(16'h5001, 0);
    check("badsync_err", {159'd0, cfg_err}, 1);
    check("badsync_ready", {159'd0, cfg_ready}, 1);
    @(negedge CLK);
    check("badsync_err_pulse", {159'd0, cfg_err}, 0);

    // Out-of-range index: five following words are swallowed, even header-like ones
    send_word(16'hA00F, 0);
    check("badidx_err", {159'd0, cfg_err}, 1);
    for (int k = 0; k < 5; k++) send_word(16'hA000, 0);
    repeat (3) @(negedge CLK);
    check("badidx_pending", {159'd0, pending}, 0);
    check("badidx_bus", coeff_bus, exp_bus());
    rand_coefs();
    send_frame(16'hA000, 1);
    model_frame(16'hA000);
    repeat (4) @(negedge CLK);
    model_commit();
    check("after_drain_bus", coeff_bus, exp_bus());

    // Reset mid-frame with a stage pending
    sample_en = 1'b1;
    rand_coefs();
    send_frame(16'hA000, 0);
    rand_coefs();
    send_word(16'hA001, 0);
    for (int k = 0; k < 3; k++) send_word(cw[k], 0);
    check("pre_rst_pending", {159'd0, pending}, 1);
    sample_en = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_ready", {159'd0, cfg_ready}, 0);
    check("rst_pending", {159'd0, pending}, 0);
    check("rst_bus", coeff_bus, exp_bus());
    @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("post_rst_bus", coeff_bus, exp_bus());
    check("post_rst_pending", {159'd0, pending}, 0);
    rand_coefs();
    send_frame(16'hA001, 2);
    model_frame(16'hA001);
    repeat (4) @(negedge CLK);
    model_commit();
    check("post_rst_frame", coeff_bus, exp_bus());

    // Two frames to stage 0 before one commit, with back-pressure gaps
    sample_en = 1'b1;
    c0 = n_commits;
    rand_coefs(); send_frame(16'hA000, 3); model_frame(16'hA000);
    rand_coefs(); send_frame(16'hA3F0, 3); model_frame(16'hA3F0);
    repeat (5) @(negedge CLK);
    check("two_pending", {159'd0, pending}, 1);
    sample_en = 1'b0;
    repeat (6) @(negedge CLK);
    model_commit();
    check("two_commits", 160'(n_commits - c0), 160'd1);
    check("two_bus", coeff_bus, exp_bus());

    // Randomized frames
    for (int it = 0; it < 12; it++) begin
      sy  = ($urandom_range(0, 3) == 0) ? 4'h5 : 4'hA;
      ix  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, NS-1));
      hdr = {sy, 8'($urandom), ix};
      se  = bit'($urandom_range(0, 1));
      sample_en = se;
      rand_coefs();
      send_word(hdr, $urandom_range(0, 2));
      if (sy == 4'hA)
        for (int k = 0; k < 5; k++) send_word(cw[k], $urandom_range(0, 2));
      model_frame(hdr);
      if (se) begin
        repeat (3) @(negedge CLK);
        check("rnd_pending", {159'd0, pending}, {159'd0, exp_pending()});
        check("rnd_held_bus", coeff_bus, exp_bus());
      end
      sample_en = 1'b0;
      repeat (4) @(negedge CLK);
      model_commit();
      check("rnd_bus", coeff_bus, exp_bus());
      check("rnd_pending_clr", {159'd0, pending}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
